// File: rtl/l2_pkg.sv
// Shared definitions for the L2 request arbiter slice.
// Latency: none (constants, types and a pure helper function).
// Backpressure: not applicable.
package l2_pkg;

   // Arbitration modes.
   localparam int PRIO_FIXED = 0;
   localparam int PRIO_RR    = 1;

   // out_port encoding width and the largest supported port count.
   localparam int PORT_W    = 3;
   localparam int MAX_PORTS = 8;

   // One-entry output register occupancy.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

   // Convert a one-hot grant into a port index (0 when nothing is set).
   function automatic logic [PORT_W-1:0] oh_to_idx(input logic [MAX_PORTS-1:0] oh);
      logic [PORT_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         if (oh[i]) idx = PORT_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/l2_req_arbiter_if.sv
// Request-side, write-back hazard and downstream bundle of the L2 request arbiter.
// Latency: none (wiring only).
// Backpressure: out_valid/out_ready toward the L2 core; addr_ok/op_ack acknowledge requesters.
interface l2_req_arbiter_if
   import l2_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
);
   // Cache-maintenance operation
   logic                        op_req;
   logic [31:0]                 op_code;
   logic [ADDR_W-1:0]           op_addr;
   logic                        op_ack;
   // Per-port requests, port k at slice k
   logic [NUM_PORTS-1:0]        req;
   logic [NUM_PORTS-1:0]        wr;
   logic [NUM_PORTS-1:0]        uc;
   logic [NUM_PORTS*ADDR_W-1:0] addr;
   logic [NUM_PORTS*DATA_W-1:0] wdata;
   logic [NUM_PORTS*4-1:0]      wstrb;
   logic [NUM_PORTS*2-1:0]      size;
   logic [NUM_PORTS-1:0]        addr_ok;
   // Write-back hazard window from the L2 FSM
   logic                        wb_set;
   logic                        wb_clr;
   logic [ADDR_W-1:0]           wb_addr;
   // Downstream to the L2 core
   logic                        out_valid;
   logic                        out_ready;
   logic                        out_is_op;
   logic [PORT_W-1:0]           out_port;
   logic [ADDR_W-1:0]           out_addr;
   logic [DATA_W-1:0]           out_wdata;
   logic [3:0]                  out_wstrb;
   logic [1:0]                  out_size;
   logic                        out_wr;
   logic                        out_uc;
   logic [31:0]                 out_opcode;

   // Requesters, hazard source and L2 core together
   modport master (
      output op_req, op_code, op_addr, req, wr, uc, addr, wdata, wstrb, size,
             wb_set, wb_clr, wb_addr, out_ready,
      input  op_ack, addr_ok, out_valid, out_is_op, out_port, out_addr, out_wdata,
             out_wstrb, out_size, out_wr, out_uc, out_opcode
   );

   // The arbiter itself
   modport slave (
      input  op_req, op_code, op_addr, req, wr, uc, addr, wdata, wstrb, size,
             wb_set, wb_clr, wb_addr, out_ready,
      output op_ack, addr_ok, out_valid, out_is_op, out_port, out_addr, out_wdata,
             out_wstrb, out_size, out_wr, out_uc, out_opcode
   );

endinterface

// File: rtl/l2_arb_pick.sv
// One-hot winner selection among request candidates (fixed with aging, or round-robin).
// Latency: purely combinational.
// Backpressure: none; caller decides whether the grant is used.
module l2_arb_pick
   import l2_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int PRIO_MODE = PRIO_FIXED
)(
   input  logic [NUM_PORTS-1:0] cand_i,
   input  logic [PORT_W-1:0]    rr_ptr_i,
   input  logic [NUM_PORTS-1:0] starve_i,
   output logic [NUM_PORTS-1:0] grant_o
);

   logic [NUM_PORTS-1:0] pool;
   logic [NUM_PORTS-1:0] fix_grant;
   logic [NUM_PORTS-1:0] rot_cand;
   logic [NUM_PORTS-1:0] rot_grant;
   logic [NUM_PORTS-1:0] rr_grant;

   // Lowest set bit of the starving pool (or all candidates), or of the rotated vector
   always_comb begin
      pool      = ((cand_i & starve_i) != '0) ? (cand_i & starve_i) : cand_i;
      fix_grant = pool & (~pool + 1'b1);
      // Rotate so rr_ptr sits at bit 0, pick lowest, rotate back
      rot_cand  = NUM_PORTS'({cand_i, cand_i} >> rr_ptr_i);
      rot_grant = rot_cand & (~rot_cand + 1'b1);
      rr_grant  = NUM_PORTS'(({rot_grant, rot_grant} << rr_ptr_i) >> NUM_PORTS);
      grant_o   = (PRIO_MODE == PRIO_RR) ? rr_grant : fix_grant;
   end

endmodule

// File: rtl/l2_req_arbiter.sv
// Arbitrates maintenance ops and per-port L1/prefetch requests into a one-entry output register.
// Latency: 1 cycle from addr_ok/op_ack to out_valid with payload.
// Backpressure: accepts only when empty or draining the same cycle (out_ready); otherwise holds out_*.
module l2_req_arbiter
   import l2_pkg::*;
#(
   parameter int NUM_PORTS     = 3,
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int LINE_OFFSET_W = 5,
   parameter int PRIO_MODE     = PRIO_FIXED,
   parameter int STARVE_LIMIT  = 15
)(
   input logic             clk,
   input logic             rst,
   l2_req_arbiter_if.slave bus
);

   localparam int WAIT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

   out_state_e           st_q, st_d;
   logic                 accept, take_op, take_port;
   logic [NUM_PORTS-1:0] masked, cand, starve, grant;
   logic [MAX_PORTS-1:0] grant8;
   logic [PORT_W-1:0]    win_idx;
   logic [PORT_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                 wb_valid_q, wb_valid_d;
   logic [ADDR_W-1:0]    wb_line_q, wb_line_d;
   logic [WAIT_W-1:0]    wait_q [NUM_PORTS];
   logic [WAIT_W-1:0]    wait_d [NUM_PORTS];
   logic                 is_op_q, is_op_d, wr_q, wr_d, uc_q, uc_d;
   logic [PORT_W-1:0]    port_q, port_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [3:0]           wstrb_q, wstrb_d;
   logic [1:0]           size_q, size_d;
   logic [31:0]          opcode_q, opcode_d;

   // Candidates: requests not hitting the pending write-back line (tag compare, no wrap)
   always_comb begin
      masked = '0;
      starve = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         masked[k] = wb_valid_q && bus.wr[k] &&
                     ((bus.addr[k*ADDR_W +: ADDR_W] >> LINE_OFFSET_W) == wb_line_q);
         starve[k] = (STARVE_LIMIT != 0) && (wait_q[k] >= WAIT_MAX);
      end
      cand = bus.req & ~masked;
   end

   l2_arb_pick #(
      .NUM_PORTS (NUM_PORTS),
      .PRIO_MODE (PRIO_MODE)
   ) u_pick (
      .cand_i   (cand),
      .rr_ptr_i (rr_ptr_q),
      .starve_i (starve),
      .grant_o  (grant)
   );

   // Acceptance decision and combinational acknowledge strobes (suppressed in reset)
   always_comb begin
      grant8                 = '0;
      grant8[NUM_PORTS-1:0]  = grant;
      win_idx                = oh_to_idx(grant8);
      accept                 = (st_q == ST_EMPTY) || bus.out_ready;
      take_op                = !rst && accept && bus.op_req;
      take_port              = !rst && accept && !bus.op_req && (cand != '0);
      bus.op_ack             = take_op;
      bus.addr_ok            = take_port ? grant : '0;
   end

   // Output-register FSM: state register
   always_ff @(posedge clk) begin
      if (rst) st_q <= ST_EMPTY;
      else     st_q <= st_d;
   end

   // Output-register FSM: next state (fill on any acceptance, drain otherwise)
   always_comb begin
      st_d = st_q;
      if (accept) st_d = (take_op || take_port) ? ST_FULL : ST_EMPTY;
   end

   // Output-register FSM: outputs
   always_comb begin
      bus.out_valid  = (st_q == ST_FULL);
      bus.out_is_op  = is_op_q;
      bus.out_port   = port_q;
      bus.out_addr   = addr_q;
      bus.out_wdata  = wdata_q;
      bus.out_wstrb  = wstrb_q;
      bus.out_size   = size_q;
      bus.out_wr     = wr_q;
      bus.out_uc     = uc_q;
      bus.out_opcode = opcode_q;
   end

   // Next payload, round-robin pointer, hazard window and aging counters
   always_comb begin
      is_op_d  = is_op_q;  port_d  = port_q;  addr_d   = addr_q;
      wdata_d  = wdata_q;  wstrb_d = wstrb_q; size_d   = size_q;
      wr_d     = wr_q;     uc_d    = uc_q;    opcode_d = opcode_q;
      rr_ptr_d = rr_ptr_q;
      if (take_op) begin
         is_op_d = 1'b1;  port_d  = '0;  addr_d = bus.op_addr;  wdata_d  = '0;
         wstrb_d = '0;    size_d  = '0;  wr_d   = 1'b0;         uc_d     = 1'b0;
         opcode_d = bus.op_code;
      end else if (take_port) begin
         is_op_d  = 1'b0;
         port_d   = win_idx;
         opcode_d = '0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant[k]) begin
               addr_d  = bus.addr[k*ADDR_W +: ADDR_W];
               wdata_d = bus.wdata[k*DATA_W +: DATA_W];
               wstrb_d = bus.wstrb[k*4 +: 4];
               size_d  = bus.size[k*2 +: 2];
               wr_d    = bus.wr[k];
               uc_d    = bus.uc[k];
            end
         end
         if (PRIO_MODE == PRIO_RR)
            rr_ptr_d = (win_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : win_idx + PORT_W'(1);
      end
      // A set in the same cycle as a clear wins, with the new line
      wb_valid_d = wb_valid_q;
      wb_line_d  = wb_line_q;
      if (bus.wb_set) begin
         wb_valid_d = 1'b1;
         wb_line_d  = bus.wb_addr >> LINE_OFFSET_W;
      end else if (bus.wb_clr) begin
         wb_valid_d = 1'b0;
      end
      // Aging: count cycles a requester loses a possible acceptance
      for (int k = 0; k < NUM_PORTS; k++) begin
         wait_d[k] = wait_q[k];
         if (!bus.req[k] || (take_port && grant[k]))   wait_d[k] = '0;
         else if (accept && (wait_q[k] != WAIT_MAX))   wait_d[k] = wait_q[k] + 1'b1;
      end
   end

   // Payload and bookkeeping registers; reset discards any held request
   always_ff @(posedge clk) begin
      if (rst) begin
         is_op_q <= 1'b0; port_q  <= '0; addr_q   <= '0; wdata_q <= '0;
         wstrb_q <= '0;   size_q  <= '0; wr_q     <= 1'b0; uc_q  <= 1'b0;
         opcode_q <= '0;  rr_ptr_q <= '0; wb_valid_q <= 1'b0; wb_line_q <= '0;
         for (int k = 0; k < NUM_PORTS; k++) wait_q[k] <= '0;
      end else begin
         is_op_q <= is_op_d; port_q  <= port_d;  addr_q   <= addr_d; wdata_q <= wdata_d;
         wstrb_q <= wstrb_d; size_q  <= size_d;  wr_q     <= wr_d;   uc_q    <= uc_d;
         opcode_q <= opcode_d; rr_ptr_q <= rr_ptr_d;
         wb_valid_q <= wb_valid_d; wb_line_q <= wb_line_d;
         for (int k = 0; k < NUM_PORTS; k++) wait_q[k] <= wait_d[k];
      end
   end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench: fixed-priority and round-robin instances share one stimulus stream
// and are compared every cycle against a behavioural model, plus directed scenario checks.
module tb_l2_req_arbiter;
   import l2_pkg::*;

   localparam int N     = 3;
   localparam int LIMIT = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        t_op_req, t_wb_set, t_wb_clr, t_ready;
   logic [31:0] t_op_code, t_op_addr, t_wb_addr;
   logic [2:0]  t_req, t_wr, t_uc;
   logic [31:0] t_addr [N];
   logic [31:0] t_wdata[N];
   logic [3:0]  t_wstrb[N];
   logic [1:0]  t_size [N];

   logic [2:0]  o_ok[2], o_port[2];
   logic        o_ack[2], o_vld[2], o_isop[2], o_wr[2], o_uc[2];
   logic [31:0] o_addr[2], o_wdata[2], o_opc[2];
   logic [3:0]  o_wstrb[2];
   logic [1:0]  o_size[2];

   for (genvar m = 0; m < 2; m++) begin : g_dut
      l2_req_arbiter_if #(.NUM_PORTS(N), .ADDR_W(32), .DATA_W(32)) bus ();
      assign bus.op_req    = t_op_req;
      assign bus.op_code   = t_op_code;
      assign bus.op_addr   = t_op_addr;
      assign bus.req       = t_req;
      assign bus.wr        = t_wr;
      assign bus.uc        = t_uc;
      assign bus.addr      = {t_addr[2], t_addr[1], t_addr[0]};
      assign bus.wdata     = {t_wdata[2], t_wdata[1], t_wdata[0]};
      assign bus.wstrb     = {t_wstrb[2], t_wstrb[1], t_wstrb[0]};
      assign bus.size      = {t_size[2], t_size[1], t_size[0]};
      assign bus.wb_set    = t_wb_set;
      assign bus.wb_clr    = t_wb_clr;
      assign bus.wb_addr   = t_wb_addr;
      assign bus.out_ready = t_ready;
      l2_req_arbiter #(
         .NUM_PORTS(N), .ADDR_W(32), .DATA_W(32), .LINE_OFFSET_W(5),
         .PRIO_MODE(m), .STARVE_LIMIT(LIMIT)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
      assign o_ok[m]    = bus.addr_ok;
      assign o_ack[m]   = bus.op_ack;
      assign o_vld[m]   = bus.out_valid;
      assign o_isop[m]  = bus.out_is_op;
      assign o_port[m]  = bus.out_port;
      assign o_addr[m]  = bus.out_addr;
      assign o_wdata[m] = bus.out_wdata;
      assign o_wstrb[m] = bus.out_wstrb;
      assign o_size[m]  = bus.out_size;
      assign o_wr[m]    = bus.out_wr;
      assign o_uc[m]    = bus.out_uc;
      assign o_opc[m]   = bus.out_opcode;
   end

   // Behavioural model state, index 0 = fixed priority, 1 = round-robin
   bit          m_vld[2], m_isop[2], m_wr[2], m_uc[2], m_wbv[2];
   int          m_port[2], m_rr[2];
   int          m_wait[2][N];
   logic [31:0] m_addr[2], m_wdata[2], m_opc[2], m_wbline[2];
   logic [3:0]  m_wstrb[2];
   logic [1:0]  m_size[2];

   // Strobes/outputs seen at the last checked cycle, for directed checks
   logic [2:0]  s_ok[2];
   logic        s_ack[2], s_vld[2], s_isop[2];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset(input int m);
      m_vld[m] = 0; m_isop[m] = 0; m_wr[m] = 0; m_uc[m] = 0; m_wbv[m] = 0;
      m_port[m] = 0; m_rr[m] = 0; m_addr[m] = 0; m_wdata[m] = 0; m_opc[m] = 0;
      m_wbline[m] = 0; m_wstrb[m] = 0; m_size[m] = 0;
      for (int k = 0; k < N; k++) m_wait[m][k] = 0;
   endtask

   // Winner by rule: fixed = starving ports first, then lowest index; rr = first at/after pointer
   function automatic int pick_winner(input int m, input logic [2:0] cand);
      if (m == 0) begin
         for (int k = 0; k < N; k++) if (cand[k] && m_wait[m][k] >= LIMIT) return k;
         for (int k = 0; k < N; k++) if (cand[k]) return k;
      end else begin
         for (int d = 0; d < N; d++) if (cand[(m_rr[m] + d) % N]) return (m_rr[m] + d) % N;
      end
      return -1;
   endfunction

   task automatic model_cycle(input int m);
      bit          acc, exp_ack;
      logic [2:0]  cand, exp_ok;
      int          w;
      string       pre;
      pre     = (m == 0) ? "fix" : "rr";
      exp_ack = 0;
      exp_ok  = '0;
      w       = -1;
      acc     = !m_vld[m] || t_ready;
      for (int k = 0; k < N; k++)
         cand[k] = t_req[k] && !(m_wbv[m] && t_wr[k] && ((t_addr[k] >> 5) == m_wbline[m]));
      if (!rst && acc && t_op_req) exp_ack = 1;
      else if (!rst && acc && cand != 0) begin
         w = pick_winner(m, cand);
         exp_ok[w] = 1'b1;
      end
      chk_eq({pre, ".op_ack"},     o_ack[m],   exp_ack);
      chk_eq({pre, ".addr_ok"},    o_ok[m],    exp_ok);
      chk_eq({pre, ".out_valid"},  o_vld[m],   m_vld[m]);
      chk_eq({pre, ".out_is_op"},  o_isop[m],  m_isop[m]);
      chk_eq({pre, ".out_port"},   o_port[m],  m_port[m]);
      chk_eq({pre, ".out_addr"},   o_addr[m],  m_addr[m]);
      chk_eq({pre, ".out_wdata"},  o_wdata[m], m_wdata[m]);
      chk_eq({pre, ".out_wstrb"},  o_wstrb[m], m_wstrb[m]);
      chk_eq({pre, ".out_size"},   o_size[m],  m_size[m]);
      chk_eq({pre, ".out_wr"},     o_wr[m],    m_wr[m]);
      chk_eq({pre, ".out_uc"},     o_uc[m],    m_uc[m]);
      chk_eq({pre, ".out_opcode"}, o_opc[m],   m_opc[m]);
      s_ok[m] = o_ok[m]; s_ack[m] = o_ack[m]; s_vld[m] = o_vld[m]; s_isop[m] = o_isop[m];
      if (rst) begin
         model_reset(m);
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!t_req[k] || w == k)                  m_wait[m][k] = 0;
            else if (acc && m_wait[m][k] < LIMIT)     m_wait[m][k]++;
         end
         if (exp_ack) begin
            m_vld[m] = 1; m_isop[m] = 1; m_port[m] = 0; m_addr[m] = t_op_addr;
            m_wdata[m] = 0; m_wstrb[m] = 0; m_size[m] = 0; m_wr[m] = 0; m_uc[m] = 0;
            m_opc[m] = t_op_code;
         end else if (w >= 0) begin
            m_vld[m] = 1; m_isop[m] = 0; m_port[m] = w; m_addr[m] = t_addr[w];
            m_wdata[m] = t_wdata[w]; m_wstrb[m] = t_wstrb[w]; m_size[m] = t_size[w];
            m_wr[m] = t_wr[w]; m_uc[m] = t_uc[w]; m_opc[m] = 0;
            if (m == 1) m_rr[m] = (w + 1) % N;
         end else if (acc) begin
            m_vld[m] = 0;
         end
         if (t_wb_set) begin
            m_wbv[m] = 1; m_wbline[m] = t_wb_addr >> 5;
         end else if (t_wb_clr) begin
            m_wbv[m] = 0;
         end
      end
   endtask

   // Inputs are set just after a rising edge; outputs are checked on the falling edge
   task automatic run_cycle();
      @(negedge clk);
      model_cycle(0);
      model_cycle(1);
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      t_op_req = 0; t_op_code = 0; t_op_addr = 0; t_req = 0; t_wr = 0; t_uc = 0;
      t_wb_set = 0; t_wb_clr = 0; t_wb_addr = 0; t_ready = 1;
      for (int k = 0; k < N; k++) begin
         t_addr[k] = 32'h4000_0000 + 32'(k * 'h100); t_wdata[k] = 32'hA0 + 32'(k);
         t_wstrb[k] = 4'hF; t_size[k] = 2'd2;
      end
   endtask

   task automatic pulse_reset();
      rst = 1; run_cycle(); rst = 0;
   endtask

   int first_p1;
   logic [31:0] pool[4];

   initial begin
      model_reset(0);
      model_reset(1);
      set_idle();
      rst = 1;
      @(posedge clk); #1;
      run_cycle();
      run_cycle();
      rst = 0;

      // Fixed mode aging: port1 starved 15 cycles, wins in cycle 16
      t_req = 3'b011;
      first_p1 = 0;
      for (int c = 1; c <= 20; c++) begin
         run_cycle();
         if (first_p1 == 0 && s_ok[0] == 3'b010) first_p1 = c;
      end
      chk_eq("starve_grant_cycle", first_p1, 16);

      // Round-robin sequence 0,1,2,0,1,2 from reset
      pulse_reset();
      t_req = 3'b111;
      for (int i = 0; i < 6; i++) begin
         run_cycle();
         chk_eq($sformatf("rr_seq%0d", i), s_ok[1], 3'b001 << (i % 3));
      end

      // Write-back hazard window
      t_req = 0; t_wb_set = 1; t_wb_addr = 32'h1000_0040;
      run_cycle();
      t_wb_set = 0;
      t_req = 3'b011; t_wr = 3'b001;
      t_addr[0] = 32'h1000_005C; t_addr[1] = 32'h1000_0044;
      run_cycle();
      chk_eq("hz_masked_read_ok", s_ok[0], 3'b010);
      t_req = 3'b001;
      run_cycle();
      chk_eq("hz_write_held", s_ok[0], 3'b000);
      t_wb_clr = 1;
      run_cycle();
      t_wb_clr = 0;
      run_cycle();
      chk_eq("hz_cleared_write_ok", s_ok[0], 3'b001);

      // Stall while full, then drain and refill in one cycle
      t_wr = 0; t_ready = 0; t_addr[0] = 32'h1000_0100;
      for (int i = 0; i < 4; i++) begin
         run_cycle();
         chk_eq("stall_no_ok", s_ok[0], 3'b000);
      end
      t_ready = 1;
      run_cycle();
      chk_eq("refill_ok", s_ok[0], 3'b001);
      chk_eq("refill_vld", s_vld[0], 1'b1);

      // Maintenance op beats all ports and leaves the round-robin pointer alone
      pulse_reset();
      t_req = 3'b111;
      run_cycle();
      t_op_req = 1; t_op_code = 32'hC0DE_0001; t_op_addr = 32'h2000_0080;
      run_cycle();
      chk_eq("op_ack", s_ack[1], 1'b1);
      chk_eq("op_no_ok", s_ok[1], 3'b000);
      t_op_req = 0;
      run_cycle();
      chk_eq("op_out_is_op", s_isop[1], 1'b1);
      chk_eq("rr_after_op", s_ok[1], 3'b010);

      // Reset while full discards the entry and the hazard window
      t_req = 3'b001; t_wr = 3'b001; t_addr[0] = 32'h2000_0010;
      t_wb_set = 1; t_wb_addr = 32'h2000_0000;
      run_cycle();
      t_wb_set = 0; t_ready = 0;
      run_cycle();
      rst = 1;
      run_cycle();
      rst = 0; t_req = 0; t_ready = 1;
      run_cycle();
      chk_eq("rst_fix_vld", s_vld[0], 1'b0);
      chk_eq("rst_rr_vld", s_vld[1], 1'b0);
      t_req = 3'b111;
      run_cycle();
      chk_eq("rst_hz_gone", s_ok[0], 3'b001);
      chk_eq("rst_rr_ptr0", s_ok[1], 3'b001);

      // Randomized traffic against the model
      pool[0] = 32'h1000_0040; pool[1] = 32'h1000_0060;
      pool[2] = 32'h3000_0000; pool[3] = 32'hFFFF_FFE0;
      set_idle();
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 1) == 0) t_req = 3'($urandom_range(0, 7));
         t_wr = 3'($urandom_range(0, 7));
         t_uc = 3'($urandom_range(0, 7));
         for (int k = 0; k < N; k++) begin
            t_addr[k]  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
            t_wdata[k] = $urandom;
            t_wstrb[k] = 4'($urandom_range(0, 15));
            t_size[k]  = 2'($urandom_range(0, 3));
         end
         t_op_req  = ($urandom_range(0, 9) == 0);
         t_op_code = $urandom;
         t_op_addr = $urandom;
         t_ready   = ($urandom_range(0, 3) != 0);
         t_wb_set  = ($urandom_range(0, 7) == 0);
         t_wb_clr  = ($urandom_range(0, 7) == 0);
         t_wb_addr = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
         rst       = ($urandom_range(0, 99) == 0);
         run_cycle();
      end
      rst = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
